// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: branch-unit redirect, instruction-memory request/response
// and the decode-side valid/ready instruction channel.
//   master : fetch unit view (drives imemReq/imemAddr, instr channel, misalign)
//   slave  : environment view (branch unit, instruction memory, decode)
interface fetch_unit_if;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [31:0] instrPC;
  logic        misalign;

  modport master (
    input  redirect, redirectPC, imemGnt, imemRvalid, imemRdata, instrReady,
    output imemReq, imemAddr, instrValid, instr, instrPC, misalign
  );

  modport slave (
    output redirect, redirectPC, imemGnt, imemRvalid, imemRdata, instrReady,
    input  imemReq, imemAddr, instrValid, instr, instrPC, misalign
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. Owns the PC, issues one word fetch at a time,
// buffers one instruction for decode and honours branch redirects by squashing
// wrong-path work.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_unit_if.master (redirect in, imem req/gnt/rvalid/rdata,
//              instr valid/ready/instr/instrPC out, sticky misalign out)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   instr_q;
  logic [XLEN-1:0]   instr_pc_q;
  logic              instr_valid_q;
  logic              misalign_q;

  logic              out_free_c;
  logic              bad_target_c;
  logic              req_c;
  logic              accept_c;
  logic              redirect_c;
  logic              fault_c;

  assign out_free_c   = !instr_valid_q || bus.instrReady;
  assign bad_target_c = bus.redirectPC[1:0] != 2'b00;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Next-state logic; an aligned redirect only changes the state when it
  // leaves an in-flight response behind (WAIT without rvalid -> DROP).
  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (bus.redirect)                                 state_next = bad_target_c ? FAULT : FETCH;
        else if (out_free_c && bus.imemGnt)               state_next = WAIT;
      end
      WAIT: begin
        if (bus.redirect && bad_target_c)                 state_next = FAULT;
        else if (bus.imemRvalid)                          state_next = FETCH;
        else if (bus.redirect)                            state_next = DROP;
      end
      DROP: begin
        if (bus.redirect && bad_target_c)                 state_next = FAULT;
        else if (bus.imemRvalid)                          state_next = FETCH;
      end
      default:                                            state_next = FAULT;
    endcase
  end

  // Output / datapath-control decode
  always_comb begin
    req_c      = 1'b0;
    accept_c   = 1'b0;
    redirect_c = 1'b0;
    fault_c    = 1'b0;
    if (state != FAULT) begin
      req_c      = (state == FETCH) && out_free_c && !bus.redirect;
      redirect_c = bus.redirect && !bad_target_c;
      fault_c    = bus.redirect && bad_target_c;
      accept_c   = (state == WAIT) && bus.imemRvalid && !bus.redirect;
    end
  end

  // PC, output register and sticky fault flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else if (fault_c) begin
      misalign_q    <= 1'b1;
      instr_valid_q <= 1'b0;
    end else if (redirect_c) begin
      pc            <= bus.redirectPC;
      instr_valid_q <= 1'b0;
    end else if (accept_c) begin
      instr_q       <= bus.imemRdata;
      instr_pc_q    <= pc;
      instr_valid_q <= 1'b1;
      pc            <= pc + XLEN'(4);
    end else if (state == FAULT || (instr_valid_q && bus.instrReady)) begin
      instr_valid_q <= 1'b0;
    end
  end

  assign bus.imemReq    = req_c;
  assign bus.imemAddr   = pc;
  assign bus.instrValid = instr_valid_q;
  assign bus.instr      = instr_q;
  assign bus.instrPC    = instr_pc_q;
  assign bus.misalign   = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: sequential fetch, decode back-pressure,
// redirect squashing, misaligned-target fault and PC wrap-around.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        gnt;
  logic        ready;
  logic        auto_rsp;
  logic        rsp_q;
  logic        man_rvalid;
  logic [31:0] man_rdata;

  int n_checks;
  int n_fail;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: when enabled, answers every grant one cycle later with 0x13
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rsp_q <= 1'b0;
    else     rsp_q <= auto_rsp && bus.imemReq && bus.imemGnt;
  end

  assign bus.redirect   = redirect;
  assign bus.redirectPC = redirect_pc;
  assign bus.imemGnt    = gnt;
  assign bus.imemRvalid = auto_rsp ? rsp_q : man_rvalid;
  assign bus.imemRdata  = auto_rsp ? 32'h0000_0013 : man_rdata;
  assign bus.instrReady = ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge (+1) where instrValid is high and check it
  task automatic wait_instr(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    bit found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (bus.instrValid) begin
        found = 1;
        break;
      end
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
    if (found) begin
      check({tag, "_pc"}, bus.instrPC, exp_pc);
      check({tag, "_instr"}, bus.instr, exp_instr);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; gnt = 1'b1; ready = 1'b1;
    auto_rsp = 1'b1; man_rvalid = 1'b0; man_rdata = '0;
    @(negedge clk); #1;
    check("rst_valid", 32'(bus.instrValid), 32'd0);
    check("rst_addr", bus.imemAddr, 32'h0);
    check("rst_instrpc", bus.instrPC, 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; gnt = 1'b1; ready = 1'b1;
    auto_rsp = 1'b1; man_rvalid = 1'b0; man_rdata = '0;

    // 1: sequential fetch
    do_reset();
    check("rst_instr", bus.instr, 32'h0);
    check("rst_misalign", 32'(bus.misalign), 32'd0);
    wait_instr("seq0", 32'h0, 32'h13);
    wait_instr("seq1", 32'h4, 32'h13);
    wait_instr("seq2", 32'h8, 32'h13);

    // 2: decode back-pressure holds the output register and blocks requests
    do_reset();
    wait_instr("bp", 32'h0, 32'h13);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("bp_req", 32'(bus.imemReq), 32'd0);
      check("bp_valid", 32'(bus.instrValid), 32'd1);
      check("bp_pc", bus.instrPC, 32'h0);
      check("bp_instr", bus.instr, 32'h13);
    end
    ready = 1'b1; #1;
    check("bp_rel_req", 32'(bus.imemReq), 32'd1);
    check("bp_rel_addr", bus.imemAddr, 32'h4);

    // 3: redirect in WAIT, response arrives later and is dropped
    do_reset();
    wait_instr("r3a", 32'h0, 32'h13);
    wait_instr("r3b", 32'h4, 32'h13);
    auto_rsp = 1'b0;                       // fetch of 0x8 is granted, left in flight
    @(negedge clk); #1;
    check("r3_addr", bus.imemAddr, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h1010; #1;
    check("r3_req_redir", 32'(bus.imemReq), 32'd0);
    @(negedge clk); #1;
    redirect = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF; #1;
    check("r3_drop_req", 32'(bus.imemReq), 32'd0);
    check("r3_drop_valid", 32'(bus.instrValid), 32'd0);
    @(negedge clk); #1;
    man_rvalid = 1'b0; #1;
    check("r3_valid", 32'(bus.instrValid), 32'd0);
    check("r3_req", 32'(bus.imemReq), 32'd1);
    check("r3_next_addr", bus.imemAddr, 32'h1010);

    // 4: redirect coincident with rvalid, then redirect squashing a buffered instr
    do_reset();
    wait_instr("r4a", 32'h0, 32'h13);
    auto_rsp = 1'b0;
    @(negedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h2000; man_rvalid = 1'b1; man_rdata = 32'h1111_1111;
    @(negedge clk); #1;
    redirect = 1'b0; man_rvalid = 1'b0; #1;
    check("r4_valid", 32'(bus.instrValid), 32'd0);
    check("r4_addr", bus.imemAddr, 32'h2000);
    check("r4_req", 32'(bus.imemReq), 32'd1);
    auto_rsp = 1'b1; ready = 1'b0;
    wait_instr("r4b", 32'h2000, 32'h13);
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h2100;
    @(negedge clk); #1;
    redirect = 1'b0; #1;
    check("r4_squash", 32'(bus.instrValid), 32'd0);
    check("r4_addr2", bus.imemAddr, 32'h2100);

    // 5: misaligned redirect is a terminal fault until reset
    do_reset();
    auto_rsp = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h1002;
    @(negedge clk); #1;
    redirect = 1'b0; #1;
    check("f_misalign", 32'(bus.misalign), 32'd1);
    check("f_req", 32'(bus.imemReq), 32'd0);
    check("f_valid", 32'(bus.instrValid), 32'd0);
    check("f_addr", bus.imemAddr, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h3000; man_rvalid = 1'b1; man_rdata = 32'h13;
    @(negedge clk); #1;
    redirect = 1'b0; man_rvalid = 1'b0; #1;
    check("f_ign_addr", bus.imemAddr, 32'h0);
    check("f_ign_valid", 32'(bus.instrValid), 32'd0);
    check("f_ign_req", 32'(bus.imemReq), 32'd0);
    check("f_sticky", 32'(bus.misalign), 32'd1);
    rst = 1'b1; #1;
    check("f_rst_misalign", 32'(bus.misalign), 32'd0);
    check("f_rst_addr", bus.imemAddr, 32'h0);

    // 6: PC wraps from 0xFFFFFFFC to 0
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    check("w_req_redir", 32'(bus.imemReq), 32'd0);
    @(negedge clk); #1;
    redirect = 1'b0;
    wait_instr("wrap", 32'hFFFF_FFFC, 32'h13);
    check("wrap_addr", bus.imemAddr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
